// File: rtl/seven_seg_scanner.sv
// Scans a 4-digit common-anode 7-segment display from a double-buffered 16-bit hex value.
// Latency: seg/an/frame_done are registered, one clock behind the refresh counter state.
// Backpressure: none; load is always accepted, a newer load overwrites an uncommitted one.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000,
  parameter int BLINK_DIV   = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic [15:0]   pending;
  logic [15:0]   active;
  logic          tick;
  logic          frame_end;
  logic [3:0]    nibble;
  logic          dark;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == 2'd3);

  // Refresh counter, digit index, and the frame counter that paces blinking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 2'd0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (frame_end) begin
        if (fcnt == FRM_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Double buffer: loads land in pending, which only moves to active at a
  // frame boundary so a frame is never drawn from two different values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 16'h0000;
      active  <= 16'h0000;
      busy    <= 1'b0;
    end else begin
      if (frame_end && busy) begin
        active <= pending;
      end
      if (load) begin
        pending <= digits;
        busy    <= 1'b1;
      end else if (frame_end) begin
        busy <= 1'b0;
      end
    end
  end

  // Select the nibble for the digit being scanned and decide whether it is dark.
  always_comb begin
    nibble = active[3:0];
    case (idx)
      2'd1:    nibble = active[7:4];
      2'd2:    nibble = active[11:8];
      2'd3:    nibble = active[15:12];
      default: nibble = active[3:0];
    endcase
    dark = (cnt < GUARD_C) | blank_mask[idx] | (blink_mask[idx] & blink_phase);
  end

  // Registered pin drivers; the guard interval keeps all anodes off while
  // the segment lines settle to the next digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (dark) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= seg_decode(nibble);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with a small refresh configuration (16-clock frames).
// Model tracks elapsed clocks since reset and derives slot/digit/blink from arithmetic.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_seven_seg_scanner;
  localparam int R  = 4;
  localparam int G  = 1;
  localparam int BD = 2;
  localparam int FR = 4 * R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: t = clocks since reset release; shown_t = the t the outputs reflect.
  int          t = 0;
  int          shown_t = -1;
  logic [15:0] m_pend = 16'h0000;
  logic [15:0] m_act = 16'h0000;
  logic        m_busy = 1'b0;
  logic [3:0]  e_an = 4'b1111;
  logic [6:0]  e_seg = 7'b1111111;
  logic        e_fd = 1'b0;
  logic        cmp_en = 1'b0;

  seven_seg_scanner #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .load       (load),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0b want %0b", name, shown_t, got, exp);
    end
  endtask

  // Behavioural model evaluated at each rising edge from pre-edge state.
  initial begin : model
    int   ix;
    int   c;
    int   frame;
    int   ph;
    logic dark;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; shown_t = -1;
        m_pend = 16'h0000; m_act = 16'h0000; m_busy = 1'b0;
        e_an = 4'b1111; e_seg = 7'b1111111; e_fd = 1'b0;
      end else begin
        c     = t % R;
        ix    = (t / R) % 4;
        frame = t / FR;
        ph    = (frame / BD) % 2;
        dark  = (c < G) || blank_mask[ix] || (blink_mask[ix] && (ph == 1));
        if (dark) begin
          e_an = 4'b1111; e_seg = 7'b1111111;
        end else begin
          e_an  = ~(4'b0001 << ix);
          e_seg = dec_tab[m_act[4*ix +: 4]];
        end
        e_fd = ((t % FR) == FR - 1);
        if (e_fd && m_busy) begin
          m_act  = m_pend;
          m_busy = 1'b0;
        end
        if (load) begin
          m_pend = digits;
          m_busy = 1'b1;
        end
        shown_t = t;
        t++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (shown_t >= 0 && (shown_t % FR) == p) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_phase %0d timeout", p);
  endtask

  task automatic load_val(input logic [15:0] v);
    digits = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  logic [15:0] t2_val [4] = '{16'h89AB, 16'hCDEF, 16'h4567, 16'h0123};
  int          t2_ph  [4] = '{5, 1, 13, 9};
  logic [6:0]  t2_seg [4] = '{7'b0001000, 7'b0001110, 7'b0011001, 7'b1111001};

  initial begin : stim
    int n_fd;
    int n_an3;
    int n_d0;
    int n_d1;

    // 1: reset, first load, first commit
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_an", 32'(an), 32'b1111);
    chk("rst_seg", 32'(seg), 32'b1111111);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    load_val(16'h3210);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_phase(5);
    chk("t1_pre_an", 32'(an), 32'b1101);
    chk("t1_pre_seg", 32'(seg), 32'b1000000);
    wait_phase(15);
    chk("t1_fd", 32'(frame_done), 32'd1);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    wait_phase(0);
    chk("t1_guard_an", 32'(an), 32'b1111);
    wait_phase(1);
    chk("t1_d0_an", 32'(an), 32'b1110);
    chk("t1_d0_seg", 32'(seg), 32'b1000000);
    wait_phase(5);
    chk("t1_d1_an", 32'(an), 32'b1101);
    chk("t1_d1_seg", 32'(seg), 32'b1111001);
    wait_phase(9);
    chk("t1_d2_an", 32'(an), 32'b1011);
    chk("t1_d2_seg", 32'(seg), 32'b0100100);
    wait_phase(13);
    chk("t1_d3_an", 32'(an), 32'b0111);
    chk("t1_d3_seg", 32'(seg), 32'b0110000);

    // 2: full decode coverage
    for (int k = 0; k < 4; k++) begin
      wait_phase(2);
      load_val(t2_val[k]);
      wait_phase(15);
      wait_phase(t2_ph[k]);
      chk("t2_seg", 32'(seg), 32'(t2_seg[k]));
      wait_phase(14);
    end

    // 3: back-to-back loads, latest wins
    wait_phase(2);
    load_val(16'h1111);
    @(negedge clk);
    load_val(16'h2222);
    chk("t3_busy", 32'(busy), 32'd1);
    wait_phase(15);
    chk("t3_busy_fall", 32'(busy), 32'd0);
    wait_phase(1);
    chk("t3_an", 32'(an), 32'b1110);
    chk("t3_seg", 32'(seg), 32'b0100100);
    n_fd = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (frame_done) n_fd++;
    end
    chk("t3_fd_count", 32'(n_fd), 32'd2);

    // 4: blanking and blinking
    blank_mask = 4'b1000;
    blink_mask = 4'b0001;
    wait_phase(15);
    n_an3 = 0; n_d0 = 0; n_d1 = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      if (!an[3]) n_an3++;
      if (an == 4'b1110) n_d0++;
      if (an == 4'b1101) n_d1++;
    end
    chk("t4_an3_low", 32'(n_an3), 32'd0);
    chk("t4_d0_lit", 32'(n_d0), 32'd6);
    chk("t4_d1_lit", 32'(n_d1), 32'd12);
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;

    // 5: load on the boundary edge while busy
    wait_phase(3);
    load_val(16'hAAAA);
    wait_phase(14);
    digits = 16'h5555;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    chk("t5_fd", 32'(frame_done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_phase(1);
    chk("t5_a_seg", 32'(seg), 32'b0001000);
    chk("t5_a_busy", 32'(busy), 32'd1);
    wait_phase(15);
    wait_phase(1);
    chk("t5_5_seg", 32'(seg), 32'b0010010);
    chk("t5_5_busy", 32'(busy), 32'd0);

    // 6: reset mid-frame with a pending value
    wait_phase(3);
    load_val(16'h1234);
    wait_phase(8);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_an", 32'(an), 32'b1111);
    chk("t6_seg", 32'(seg), 32'b1111111);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    wait_phase(1);
    chk("t6_d0_an", 32'(an), 32'b1110);
    chk("t6_d0_seg", 32'(seg), 32'b1000000);
    repeat (2 * FR) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
